// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 boot-time configuration path: FSM encoding,
// ROM marker words, default timing and the sensor's SCCB write ID.
package ov7670_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StPwrup,
    StSettle,
    StFetch,
    StDecode,
    StReq,
    StWait,
    StDelay,
    StDone,
    StError
  } cfg_state_e;

  localparam logic [15:0] CFG_END        = 16'hFFFF;
  localparam logic [7:0]  CFG_DELAY_HI   = 8'hFE;
  localparam logic [7:0]  OV7670_SCCB_ID = 8'h42;

  localparam int unsigned DEF_RST_CYCLES    = 25000;
  localparam int unsigned DEF_SETTLE_CYCLES = 250000;
  localparam int unsigned DEF_DELAY_UNIT    = 25000;
  localparam int unsigned DEF_NUM_REGS      = 128;
  localparam int unsigned DEF_ROM_AW        = 7;
  localparam int unsigned DEF_MAX_RETRIES   = 3;

  // Width of the shared down-counter: enough to hold the longest wait.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// Synchronous register-table ROM, 1-cycle latency, {reg_addr, reg_data} words.
// INIT is the flat image built from the hex register table (entry 0 in the LSBs).
module ov7670_cfg_rom
  import ov7670_pkg::*;
#(
  parameter int unsigned            NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned            ROM_AW   = DEF_ROM_AW,
  parameter logic [NUM_REGS*16-1:0] INIT     = '1
) (
  input  logic              i_clk,
  input  logic [ROM_AW-1:0] i_addr,
  output logic [15:0]       o_data
);

  logic [15:0] mem [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem[i] = INIT[i*16 +: 16];
    end
  end

  // Addresses past the table read as the end marker.
  always_ff @(posedge i_clk) begin
    if (32'(i_addr) < NUM_REGS) begin
      o_data <= mem[i_addr];
    end else begin
      o_data <= CFG_END;
    end
  end

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 boot sequencer: PWDN/RESET pin sequence, settle wait, then walks the
// register ROM issuing SCCB writes. Optional NACK retry under CFG_NACK_RETRY_EN.
module ov7670_cfg_sequencer
  import ov7670_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned DELAY_UNIT    = DEF_DELAY_UNIT,
  parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
  parameter int unsigned ROM_AW        = DEF_ROM_AW,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ROM_AW-1:0] o_err_idx,
  output logic              o_cam_pwdn,
  output logic              o_cam_rst_n,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [7:0]        o_wr_addr,
  output logic [7:0]        o_wr_data,
  input  logic              i_wr_done,
  input  logic              i_wr_nack
);

  localparam int unsigned CW = cnt_width(RST_CYCLES, SETTLE_CYCLES, 255 * DELAY_UNIT);
  localparam logic [CW-1:0]     RstLoad    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]     SettleLoad = CW'(SETTLE_CYCLES - 1);
  localparam logic [ROM_AW-1:0] LastIdx    = ROM_AW'(NUM_REGS - 1);

  cfg_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q, err_q, pwdn_q, cam_rst_n_q, wr_valid_q;
  logic [ROM_AW-1:0] err_idx_q, rom_addr_q;
  logic [7:0]        wr_addr_q, wr_data_q;
  logic              adv;

`ifdef CFG_NACK_RETRY_EN
  localparam int unsigned RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
  logic [RW-1:0] retry_q;
`endif

  // Entry finished: zero-length delay, expired delay, or acknowledged write.
  always_comb begin
    adv = 1'b0;
    unique case (state_q)
      StDecode: adv = (i_rom_data[15:8] == CFG_DELAY_HI) && (i_rom_data[7:0] == 8'h00);
      StDelay:  adv = (cnt_q == '0);
      StWait:   adv = i_wr_done && !i_wr_nack;
      default:  adv = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_idx_q   <= '0;
      pwdn_q      <= 1'b1;
      cam_rst_n_q <= 1'b0;
      rom_addr_q  <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
`ifdef CFG_NACK_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (i_start) begin
            state_q     <= StPwrup;
            cnt_q       <= RstLoad;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pwdn_q      <= 1'b0;
            cam_rst_n_q <= 1'b0;
`ifdef CFG_NACK_RETRY_EN
            retry_q     <= '0;
`endif
          end
        end
        StPwrup: begin
          if (cnt_q == '0) begin
            cam_rst_n_q <= 1'b1;
            cnt_q       <= SettleLoad;
            state_q     <= StSettle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            rom_addr_q <= '0;
            state_q    <= StFetch;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFetch: state_q <= StDecode;
        StDecode: begin
          if (i_rom_data == CFG_END) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (i_rom_data[15:8] == CFG_DELAY_HI) begin
            if (i_rom_data[7:0] != 8'h00) begin
              cnt_q   <= CW'(32'(i_rom_data[7:0]) * DELAY_UNIT - 1);
              state_q <= StDelay;
            end
          end else begin
            wr_addr_q  <= i_rom_data[15:8];
            wr_data_q  <= i_rom_data[7:0];
            wr_valid_q <= 1'b1;
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (i_wr_ready) begin
            wr_valid_q <= 1'b0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (i_wr_done && i_wr_nack) begin
`ifdef CFG_NACK_RETRY_EN
            if (32'(retry_q) >= MAX_RETRIES - 1) begin
              state_q   <= StError;
              err_q     <= 1'b1;
              busy_q    <= 1'b0;
              err_idx_q <= rom_addr_q;
            end else begin
              retry_q    <= retry_q + 1'b1;
              wr_valid_q <= 1'b1;
              state_q    <= StReq;
            end
`else
            state_q   <= StError;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            err_idx_q <= rom_addr_q;
`endif
          end
        end
        StDelay: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (adv) begin
`ifdef CFG_NACK_RETRY_EN
        retry_q <= '0;
`endif
        if (rom_addr_q == LastIdx) begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          rom_addr_q <= rom_addr_q + 1'b1;
          state_q    <= StFetch;
        end
      end
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_err_idx   = err_idx_q;
  assign o_cam_pwdn  = pwdn_q;
  assign o_cam_rst_n = cam_rst_n_q;
  assign o_rom_addr  = rom_addr_q;
  assign o_wr_valid  = wr_valid_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Directed bench for ov7670_cfg_sequencer with a 1-cycle ROM model and an SCCB
// master model (ready 3 cycles after valid, done 50 cycles after accept).
`timescale 1ns/1ps
module tb_ov7670_cfg_sequencer;

  localparam int unsigned RstC = 10;
  localparam int unsigned SetC = 20;
  localparam int unsigned DlyU = 5;
  localparam int unsigned NReg = 4;
  localparam int unsigned Aw   = 2;
  localparam int unsigned MaxR = 3;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, err, pwdn, cam_rst_n, wr_valid, wr_ready, wr_done, wr_nack;
  logic [Aw-1:0] err_idx, rom_addr;
  logic [15:0]   rom_data;
  logic [7:0]    wr_addr, wr_data;

  logic [15:0] rom_mem [NReg];
  logic [7:0]  log_a [64];
  logic [7:0]  log_d [64];
  bit          nack_plan [64];
  logic [7:0]  first_a, first_d;
  int          n_req;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  ov7670_cfg_sequencer #(
    .RST_CYCLES   (RstC),
    .SETTLE_CYCLES(SetC),
    .DELAY_UNIT   (DlyU),
    .NUM_REGS     (NReg),
    .ROM_AW       (Aw),
    .MAX_RETRIES  (MaxR)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_idx  (err_idx),
    .o_cam_pwdn (pwdn),
    .o_cam_rst_n(cam_rst_n),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data),
    .o_wr_valid (wr_valid),
    .i_wr_ready (wr_ready),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .i_wr_done  (wr_done),
    .i_wr_nack  (wr_nack)
  );

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin : sccb_model
    int m_cnt;
    bit m_wait;
    m_cnt = 0; m_wait = 0; n_req = 0;
    wr_ready = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
    for (int i = 0; i < 64; i++) nack_plan[i] = 1'b0;
    forever begin
      @(negedge clk);
      wr_ready = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
      if (rst) begin
        m_cnt = 0; m_wait = 0;
      end else if (!m_wait && wr_valid) begin
        m_cnt++;
        if (m_cnt == 1) begin
          first_a = wr_addr; first_d = wr_data;
        end else begin
          check("stable_addr", {24'd0, wr_addr}, {24'd0, first_a});
          check("stable_data", {24'd0, wr_data}, {24'd0, first_d});
        end
        if (m_cnt == 3) begin
          wr_ready = 1'b1;
          log_a[n_req] = wr_addr; log_d[n_req] = wr_data;
          m_wait = 1; m_cnt = 0;
        end
      end else if (m_wait) begin
        m_cnt++;
        if (m_cnt == 50) begin
          wr_done = 1'b1; wr_nack = nack_plan[n_req];
          if (n_req < 63) n_req++;
          m_wait = 0; m_cnt = 0;
        end
      end
    end
  end

  task automatic load_rom(input logic [15:0] w0, w1, w2, w3);
    rom_mem[0] = w0; rom_mem[1] = w1; rom_mem[2] = w2; rom_mem[3] = w3;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", {31'd0, done | err}, 32'd1);
  endtask

  task automatic wait_rstn(output int n);
    n = 0;
    while (!cam_rst_n && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : main
    int n, base;
    rst = 1'b1; start = 1'b0;
    load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_idx", err_idx, 0);
    check("rst_pwdn", pwdn, 1);
    check("rst_cam_rst_n", cam_rst_n, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Power-up timing and normal walk.
    load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
    base = n_req;
    pulse_start();
    check("pwdn_fall", pwdn, 0);
    check("rstn_low", cam_rst_n, 0);
    check("busy_set", busy, 1);
    wait_rstn(n);
    check("rstn_rise_cycles", n, RstC);
    n = 0;
    while (!wr_valid && n < 200) begin @(negedge clk); n++; end
    check("first_req_cycles", n, SetC + 2);
    check("first_req_addr0", rom_addr, 0);
    wait_end(2000);
    check("walk_nreq", n_req - base, 2);
    check("walk_w0", {log_a[base], log_d[base]}, 16'h1280);
    check("walk_w1", {log_a[base+1], log_d[base+1]}, 16'h1204);
    check("walk_done", done, 1);
    check("walk_busy", busy, 0);
    check("walk_err", err, 0);
    check("walk_pwdn", pwdn, 0);
    check("walk_rstn", cam_rst_n, 1);

    // Zero delay then a 2-unit delay.
    load_rom(16'hFE00, 16'hFE02, 16'h1100, 16'hFFFF);
    base = n_req;
    pulse_start();
    check("rerun_done_clr", done, 0);
    wait_rstn(n);
    n = 0;
    while (rom_addr != 1 && n < 200) begin @(negedge clk); n++; end
    check("fe00_no_delay", n, SetC + 2);
    n = 0;
    while (!wr_valid && n < 200) begin @(negedge clk); n++; end
    check("fe02_delay_cycles", n, 2 * DlyU + 4);
    wait_end(2000);
    check("dly_nreq", n_req - base, 1);
    check("dly_w", {log_a[base], log_d[base]}, 16'h1100);
    check("dly_done", done, 1);

    // NACK on the second write.
    load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
    base = n_req;
`ifdef CFG_NACK_RETRY_EN
    nack_plan[base+1] = 1'b1; nack_plan[base+2] = 1'b1; nack_plan[base+3] = 1'b1;
`else
    nack_plan[base+1] = 1'b1;
`endif
    pulse_start();
    wait_end(3000);
    check("nack_err", err, 1);
    check("nack_err_idx", err_idx, 1);
    check("nack_done", done, 0);
    check("nack_busy", busy, 0);
    repeat (200) @(negedge clk);
`ifdef CFG_NACK_RETRY_EN
    check("nack_nreq", n_req - base, 4);
    check("nack_retry_w", {log_a[base+3], log_d[base+3]}, 16'h1204);
`else
    check("nack_nreq", n_req - base, 2);
`endif
    check("nack_no_valid", wr_valid, 0);
`ifdef CFG_NACK_RETRY_EN
    base = n_req;
    nack_plan[base+1] = 1'b1; nack_plan[base+2] = 1'b1;
    pulse_start();
    wait_end(3000);
    check("retry_ok_done", done, 1);
    check("retry_ok_err", err, 0);
    check("retry_ok_nreq", n_req - base, 4);
`endif

    // ROM boundary without an end marker.
    load_rom(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    base = n_req;
    pulse_start();
    check("bnd_err_clr", err, 0);
    wait_end(3000);
    check("bnd_nreq", n_req - base, 4);
    check("bnd_w3", {log_a[base+3], log_d[base+3]}, 16'h4444);
    check("bnd_done", done, 1);
    repeat (20) @(negedge clk);
    check("bnd_addr_hold", rom_addr, 3);

    // Reset while a request is pending.
    load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
    base = n_req;
    pulse_start();
    n = 0;
    while (!wr_valid && n < 200) begin @(negedge clk); n++; end
    check("abort_in_req", wr_valid, 1);
    rst = 1'b1;
    #1;
    check("abort_valid", wr_valid, 0);
    check("abort_pwdn", pwdn, 1);
    check("abort_rstn", cam_rst_n, 0);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_nreq", n_req - base, 0);

    // Start during a delay is ignored.
    load_rom(16'hFE02, 16'h1100, 16'hFFFF, 16'hFFFF);
    base = n_req;
    pulse_start();
    wait_rstn(n);
    repeat (SetC + 5) @(negedge clk);
    pulse_start();
    check("ign_rstn", cam_rst_n, 1);
    check("ign_busy", busy, 1);
    wait_end(2000);
    check("ign_done", done, 1);
    check("ign_nreq", n_req - base, 1);

    // Start after DONE reruns the whole sequence.
    load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
    base = n_req;
    pulse_start();
    check("again_done_clr", done, 0);
    check("again_rstn_low", cam_rst_n, 0);
    wait_end(3000);
    check("again_done", done, 1);
    check("again_nreq", n_req - base, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ov7670_cfg_sequencer.md
Name: ov7670_cfg_sequencer

Overview:
Boot-time sequencer for the OV7670 camera. Performs the power-up pin sequence (PWDN, RESET), waits for the sensor to settle, then walks a register ROM of {reg_addr, reg_data} pairs. Each entry is issued as an SCCB write to the downstream SCCB master through a valid/ready plus done/nack handshake. Sits between top-level control and the SCCB master; signals completion so the capture path can be enabled.

Parameters:
RST_CYCLES, 25000, cycles o_cam_rst_n is held low (1 ms at 25 MHz)
SETTLE_CYCLES, 250000, cycles waited after reset release before the first write (10 ms)
DELAY_UNIT, 25000, cycles per unit of a ROM delay entry (1 ms)
NUM_REGS, 128, ROM depth in entries
ROM_AW, 7, ROM address width (>= clog2(NUM_REGS))
MAX_RETRIES, 3, NACK retries per entry (only used with CFG_NACK_RETRY_EN)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_start  in  1  single-cycle pulse; starts the full sequence
o_busy  out  1  high from accepted start until DONE or ERROR
o_done  out  1  high in DONE; cleared on the next accepted start
o_err  out  1  high in ERROR; cleared on the next accepted start
o_err_idx  out  ROM_AW  ROM index of the failing entry
o_cam_pwdn  out  1  sensor power-down pin, active-high
o_cam_rst_n  out  1  sensor reset pin, active-low
o_rom_addr  out  ROM_AW  config ROM address
i_rom_data  in  16  ROM word {addr[15:8], data[7:0]}; valid 1 cycle after o_rom_addr changes
o_wr_valid  out  1  SCCB write request
i_wr_ready  in  1  SCCB master accepts a request
o_wr_addr  out  8  register address
o_wr_data  out  8  register data
i_wr_done  in  1  one-cycle pulse when the SCCB transaction finishes
i_wr_nack  in  1  qualified by i_wr_done; 1 means the slave did not acknowledge

Behaviour:
- Reset values: o_busy=0, o_done=0, o_err=0, o_err_idx=0, o_cam_pwdn=1, o_cam_rst_n=0, o_rom_addr=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0. Reset is asynchronous, so it can abort any state, including a pending request.
- States: IDLE, PWRUP, SETTLE, FETCH, DECODE, REQ, WAIT, DELAY, DONE, ERROR.
- IDLE/DONE/ERROR + i_start: clear o_done, o_err and the counter; set o_busy; go to PWRUP. i_start is ignored in every other state.
- PWRUP: o_cam_pwdn=0, o_cam_rst_n=0 for RST_CYCLES cycles. Then o_cam_rst_n=1 and go to SETTLE.
- SETTLE: wait SETTLE_CYCLES cycles, set o_rom_addr=0, go to FETCH.
- FETCH: one wait cycle for ROM latency, then DECODE.
- DECODE, evaluated on i_rom_data:
  - 16'hFFFF is the end marker: go to DONE.
  - High byte 8'hFE is a delay entry: load low byte × DELAY_UNIT and go to DELAY. A count of 0 advances immediately.
  - Anything else: latch o_wr_addr/o_wr_data and go to REQ.
- REQ: o_wr_valid=1, with o_wr_addr/o_wr_data held stable until valid&ready in the same cycle. The next cycle sets o_wr_valid=0 and goes to WAIT.
- WAIT: on i_wr_done with i_wr_nack=0, advance. On i_wr_done with i_wr_nack=1, go to ERROR with o_err_idx=o_rom_addr.
- Advance:
  - o_rom_addr==NUM_REGS-1: go to DONE (no end marker needed at the ROM boundary; no wrap).
  - Otherwise: o_rom_addr+1, then FETCH.
- DONE: o_done=1, o_busy=0. The pins stay powered (pwdn=0, rst_n=1).
- ERROR: o_err=1, o_busy=0. The pins stay powered.
- Counters: one shared down-counter, width clog2(max(RST_CYCLES, SETTLE_CYCLES, 255×DELAY_UNIT)+1). Expiry occurs when the count reaches 0.
- Minimum per-write overhead: FETCH, DECODE, REQ and one cycle after handshake, plus the SCCB time.

Optional Feature:
CFG_NACK_RETRY_EN
- Defined: a NACK in WAIT increments a per-entry retry counter and returns to REQ with the same addr/data. ERROR is entered only after MAX_RETRIES consecutive NACKs on that entry. The retry counter clears on every advance.
- Undefined: the first NACK goes straight to ERROR, and no retry counter is synthesized.

Decomposition:
- Shared package ov7670_pkg holds:
  - state encoding
  - ROM marker constants CFG_END=16'hFFFF and CFG_DELAY_HI=8'hFE
  - default timing constants
  - OV7670 SCCB write ID 8'h42
- Sub-module ov7670_cfg_rom: synchronous ROM with 1-cycle latency, ROM_AW address and 16-bit data, initialised from a hex file. Instantiated beside the sequencer, not inside it.

Test Plan:
- Power-up timing. Stimulus: RST_CYCLES=10, SETTLE_CYCLES=20, i_start pulse. Required: o_cam_pwdn falls 1 cycle after start; o_cam_rst_n rises 10 cycles later; o_rom_addr=0 and the first o_wr_valid appear ≥20 cycles after that.
- Normal walk. Stimulus: ROM {1280, 1204, FFFF}, SCCB model with ready after 3 cycles and done/ack after 50. Required: exactly 2 writes (12/80, 12/04) with addr/data stable while valid&!ready; o_done=1, o_busy=0.
- Delay entry. Stimulus: ROM {FE02, 1100, FFFF}, DELAY_UNIT=5. Required: ≥10 cycles between DECODE of FE02 and the 11/00 request. Also FE00 advances with no delay.
- NACK. Stimulus: 2nd write answered nack=1. Required with macro undefined: o_err=1, o_err_idx=1, no further requests. Required with macro defined and MAX_RETRIES=3: the same write is retried, ERROR after the 3rd consecutive NACK, while a NACK,NACK,ack pattern reaches DONE.
- ROM boundary. Stimulus: NUM_REGS=4, no end marker. Required: 4 writes, DONE, o_rom_addr stays at 3.
- Reset and start handling. Stimulus: i_rst asserted during REQ, then i_start during DELAY. Required: o_wr_valid=0 and o_cam_pwdn=1 immediately on reset; the start during DELAY is ignored; an i_start after DONE reruns the whole sequence with o_done cleared.
